// File: rtl/serial_adder_if.sv
// serial_adder_if: start/result handshake bundle; start_valid/ready, a_in, b_in, c_in in, sum_out, c_out, out_valid/ready, busy out
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic [WIDTH-1:0] sum_out;
  logic             c_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  modport master (
    output start_valid, a_in, b_in, c_in, out_ready,
    input  start_ready, sum_out, c_out, out_valid, busy
  );
  modport slave (
    input  start_valid, a_in, b_in, c_in, out_ready,
    output start_ready, sum_out, c_out, out_valid, busy
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder over one full_adder; ports clk, rst_n (async active-low), bus (serial_adder_if.slave)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_n, sum_q;
  logic [CW-1:0]    cnt;
  logic             carry, cout_q, s, co, last;
  full_adder u_fa (.a(a_sr[0]), .b(b_sr[0]), .c_in(carry), .s(s), .c_out(co));
  assign sum_n = (sum_sr >> 1) | (WIDTH'(s) << (WIDTH - 1));
  assign last  = cnt == CW'(WIDTH - 1);
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && bus.start_valid) ? RUN :
              (state == RUN && last)             ? DONE :
              (state == DONE && bus.out_ready)   ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.start_valid) begin
        a_sr  <= bus.a_in;
        b_sr  <= bus.b_in;
        carry <= bus.c_in;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        sum_sr <= sum_n;
        carry  <= co;
        cnt    <= cnt + CW'(1);
        if (last) begin
          sum_q  <= sum_n;
          cout_q <= co;
        end
      end
    end
  end
  assign bus.start_ready = state == IDLE;
  assign bus.out_valid   = state == DONE;
  assign bus.busy        = state != IDLE;
  assign bus.sum_out     = sum_q;
  assign bus.c_out       = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH=8 plus exhaustive WIDTH=4 sweep
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();
  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  assign bus4.out_ready = 1'b1;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] es, input logic ec, input string t);
    int n;
    bus8.a_in = a;
    bus8.b_in = b;
    bus8.c_in = c;
    bus8.start_valid = 1'b1;
    @(posedge clk); #1;
    bus8.start_valid = 1'b0;
    bus8.a_in = 8'hEE;
    bus8.b_in = 8'hEE;
    n = 0;
    while (!bus8.out_valid && n < 20) begin
      chk({t, "_rdy_run"}, 32'(bus8.start_ready), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    chk({t, "_latency"}, 32'(n), 32'd8);
    chk({t, "_sum"}, 32'(bus8.sum_out), 32'(es));
    chk({t, "_cout"}, 32'(bus8.c_out), 32'(ec));
    chk({t, "_rdy_done"}, 32'(bus8.start_ready), 32'd0);
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    chk({t, "_idle"}, 32'(bus8.start_ready), 32'd1);
  endtask
  initial begin
    int n;
    bus8.start_valid = 1'b0;
    bus8.a_in = '0;
    bus8.b_in = '0;
    bus8.c_in = 1'b0;
    bus8.out_ready = 1'b0;
    bus4.start_valid = 1'b0;
    bus4.a_in = '0;
    bus4.b_in = '0;
    bus4.c_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_sum", 32'(bus8.sum_out), 32'h00);
    chk("rst_cout", 32'(bus8.c_out), 32'd0);
    chk("rst_valid", 32'(bus8.out_valid), 32'd0);
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_ready", 32'(bus8.start_ready), 32'd1);
    op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "basic");
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "carry_ff");
    op8(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, "carry_5a");
    op8(8'h10, 8'h20, 1'b1, 8'h31, 1'b0, "plain");
    bus8.a_in = 8'h22;
    bus8.b_in = 8'h33;
    bus8.c_in = 1'b0;
    bus8.start_valid = 1'b1;
    @(posedge clk); #1;
    bus8.start_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    bus8.a_in = 8'h11;
    bus8.b_in = 8'h11;
    bus8.c_in = 1'b1;
    bus8.start_valid = 1'b1;
    @(posedge clk); #1;
    bus8.start_valid = 1'b0;
    chk("bp_busy_run", 32'(bus8.busy), 32'd1);
    n = 0;
    while (!bus8.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_lat", 32'(n), 32'd5);
    bus8.start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus8.out_valid), 32'd1);
      chk("bp_sum", 32'(bus8.sum_out), 32'h55);
      chk("bp_cout", 32'(bus8.c_out), 32'd0);
      chk("bp_rdy", 32'(bus8.start_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus8.start_valid = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_noqueue_busy", 32'(bus8.busy), 32'd0);
      chk("bp_hold_sum", 32'(bus8.sum_out), 32'h55);
      @(posedge clk); #1;
    end
    op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "after_bp");
    bus8.a_in = 8'h0F;
    bus8.b_in = 8'h0F;
    bus8.c_in = 1'b0;
    bus8.start_valid = 1'b1;
    @(posedge clk); #1;
    bus8.start_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus8.out_valid), 32'd0);
    chk("mid_rst_sum", 32'(bus8.sum_out), 32'h00);
    chk("mid_rst_cout", 32'(bus8.c_out), 32'd0);
    chk("mid_rst_busy", 32'(bus8.busy), 32'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus8.start_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_noresult", 32'(bus8.out_valid), 32'd0);
    end
    op8(8'h0F, 8'h0F, 1'b0, 8'h1E, 1'b0, "post_rst");
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          bus4.a_in = 4'(a);
          bus4.b_in = 4'(b);
          bus4.c_in = 1'(c);
          bus4.start_valid = 1'b1;
          @(posedge clk); #1;
          bus4.start_valid = 1'b0;
          n = 0;
          while (!bus4.out_valid && n < 12) begin
            @(posedge clk); #1;
            n++;
          end
          chk("w4_lat", 32'(n), 32'd4);
          chk("w4_result", 32'({bus4.c_out, bus4.sum_out}), 32'(a + b + c));
          @(posedge clk); #1;
        end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
